// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
//
// Multi-channel push-button / switch debouncer. All channels share a single
// sample-tick divider. Each raw input is brought into the clock domain through
// a 2-FF synchroniser and then filtered. A channel's debounced level only
// changes after STABLE_CNT consecutive sample ticks that disagree with it. A
// registered one-clock rise or fall pulse marks each change.
//
// Parameters:
//   N_CH        number of independent channels (>= 1)
//   TICK_DIV    clk cycles per sample tick (>= 1, 1 = tick every cycle)
//   STABLE_CNT  consecutive differing samples needed to flip an output (>= 1)
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst_a_p  asynchronous active-high reset
//   en       sample enable, 0 freezes the divider and all channel state
//   din      raw asynchronous inputs, bit i = channel i
//   dout     debounced level per channel
//   rise     one-clk pulse when dout[i] goes 0->1
//   fall     one-clk pulse when dout[i] goes 1->0
//   tick     sample strobe, high one clk per TICK_DIV cycles while en=1
// ---------------------------------------------------------------------------
module debouncer_multi #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 5000,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst_a_p,
    input  logic            en,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    // A divide-by-1 still needs a one-bit counter so that the compare is legal.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [N_CH-1:0]  sync_s1;
    logic [N_CH-1:0]  sync_s2;
    logic [CNT_W-1:0] cnt [N_CH];

    // Two-stage synchroniser. It runs regardless of en so that the channel
    // logic always sees a settled, recent copy of the pins.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= din;
            sync_s2 <= sync_s1;
        end
    end

    // Shared sample-tick divider. tick is registered, so it is high in the
    // cycle after the counter reaches its last value. With en low the phase
    // is held, and re-enabling resumes exactly where it stopped.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Per-channel stability filter. On every tick, any sample that agrees
    // with the current output restarts that channel's count. Only a run of
    // STABLE_CNT disagreeing samples flips the output, and the flip fires
    // the matching edge pulse. The pulses default low on every other edge,
    // so each one lasts exactly one clock.
    // en is also checked here. A tick that was already registered when en
    // dropped therefore cannot move any channel state while the block is
    // frozen.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            dout <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (tick && en) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (sync_s2[i] == dout[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        cnt[i]  <= '0;
                        dout[i] <= sync_s2[i];
                        rise[i] <= sync_s2[i];
                        fall[i] <= ~sync_s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_debouncer_multi
//
// Directed testbench for debouncer_multi with N_CH=4, TICK_DIV=4 and
// STABLE_CNT=3. Ticks land after every 4th clock edge. The filter acts on the
// edge that follows a tick, so a level change driven just after a tick edge
// reaches dout 13 edges later.
// ---------------------------------------------------------------------------
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst_a_p;
    logic       en;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       tick;

    int         checkCount = 0;
    int         passCount  = 0;
    int         rise1Count = 0;
    logic [3:0] riseSeen   = '0;
    logic [3:0] fallSeen   = '0;
    logic       tickSeen   = 1'b0;

    debouncer_multi #(
        .N_CH      (4),
        .TICK_DIV  (4),
        .STABLE_CNT(3)
    ) dut (
        .clk    (clk),
        .rst_a_p(rst_a_p),
        .en     (en),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .tick   (tick)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] dinValue, input logic enValue);
        din = dinValue;
        en  = enValue;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected)
            passCount = passCount + 1;
        else
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic clearMonitors();
        riseSeen   = '0;
        fallSeen   = '0;
        tickSeen   = 1'b0;
        rise1Count = 0;
    endtask

    // Advance n rising edges and sample 1 ns after each one, folding the
    // pulse outputs into the monitors as we go.
    task automatic stepClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            riseSeen   = riseSeen | rise;
            fallSeen   = fallSeen | fall;
            tickSeen   = tickSeen | tick;
            rise1Count = rise1Count + int'(rise[1]);
        end
    endtask

    // Park just after an edge on which tick is observed high.
    task automatic waitTick();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            stepClk(1);
            if (tick) found = 1'b1;
        end
        checkOutput("tick_wait", 32'(found), 32'h1);
    endtask

    initial begin
        // Power-on reset
        rst_a_p = 1'b1;
        applyStimulus(4'b0000, 1'b1);
        stepClk(3);
        checkOutput("reset_dout", 32'(dout), 32'h0);
        checkOutput("reset_rise", 32'(rise), 32'h0);
        checkOutput("reset_fall", 32'(fall), 32'h0);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        @(posedge clk);
        #3;
        rst_a_p = 1'b0;

        // Tick cadence: high after edges 4 and 8 following release
        for (int i = 1; i <= 8; i++) begin
            stepClk(1);
            checkOutput("tick_cadence", 32'(tick), 32'((i % 4) == 0));
        end

        // Clean press on channel 0, driven right after the tick edge
        $display("[TB] clean press");
        clearMonitors();
        applyStimulus(4'b0001, 1'b1);
        stepClk(12);
        checkOutput("press_wait_dout", 32'(dout), 32'h0);
        checkOutput("press_wait_rise", 32'(riseSeen), 32'h0);
        stepClk(1);
        checkOutput("press_dout", 32'(dout), 32'h1);
        checkOutput("press_rise", 32'(rise), 32'h1);
        stepClk(1);
        checkOutput("press_rise_clear", 32'(rise), 32'h0);
        checkOutput("press_no_fall", 32'(fallSeen), 32'h0);

        // Bounce on channel 1: 2 ticks high, 1 tick low, five times
        $display("[TB] bounce rejection");
        waitTick();
        clearMonitors();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(4'b0011, 1'b1);
            stepClk(8);
            applyStimulus(4'b0001, 1'b1);
            stepClk(4);
        end
        checkOutput("bounce_no_rise", 32'(rise1Count), 32'h0);
        checkOutput("bounce_dout", 32'(dout), 32'h1);
        applyStimulus(4'b0011, 1'b1);
        stepClk(12);
        checkOutput("bounce_hold_dout", 32'(dout), 32'h1);
        stepClk(1);
        checkOutput("bounce_final_dout", 32'(dout), 32'h3);
        checkOutput("bounce_final_rise", 32'(rise), 32'h2);
        stepClk(3);
        checkOutput("bounce_rise_count", 32'(rise1Count), 32'h1);

        // Channels 3:2 debounce high, then release together
        $display("[TB] simultaneous release");
        waitTick();
        applyStimulus(4'b1111, 1'b1);
        stepClk(14);
        checkOutput("multi_high_dout", 32'(dout), 32'hF);
        waitTick();
        clearMonitors();
        applyStimulus(4'b0011, 1'b1);
        stepClk(12);
        checkOutput("multi_wait_dout", 32'(dout), 32'hF);
        checkOutput("multi_wait_fall", 32'(fallSeen), 32'h0);
        stepClk(1);
        checkOutput("multi_low_dout", 32'(dout), 32'h3);
        checkOutput("multi_fall", 32'(fall), 32'hC);
        checkOutput("multi_no_rise", 32'(rise), 32'h0);
        stepClk(1);
        checkOutput("multi_fall_clear", 32'(fall), 32'h0);

        // en freeze after two agreeing ticks on a channel 0 release
        $display("[TB] enable freeze");
        waitTick();
        applyStimulus(4'b0010, 1'b1);
        stepClk(9);
        checkOutput("freeze_pre_dout", 32'(dout), 32'h3);
        applyStimulus(4'b0010, 1'b0);
        clearMonitors();
        stepClk(20);
        checkOutput("freeze_no_tick", 32'(tickSeen), 32'h0);
        checkOutput("freeze_dout", 32'(dout), 32'h3);
        applyStimulus(4'b0010, 1'b1);
        stepClk(2);
        checkOutput("resume_tick_low", 32'(tick), 32'h0);
        stepClk(1);
        checkOutput("resume_tick", 32'(tick), 32'h1);
        checkOutput("resume_dout_hold", 32'(dout), 32'h3);
        stepClk(1);
        checkOutput("resume_dout", 32'(dout), 32'h2);
        checkOutput("resume_fall", 32'(fall), 32'h1);

        // Reset mid-count, asserted between clock edges
        $display("[TB] reset mid-count");
        waitTick();
        applyStimulus(4'b0011, 1'b1);
        stepClk(9);
        checkOutput("midrst_pre_dout", 32'(dout), 32'h2);
        #2;
        rst_a_p = 1'b1;
        #1;
        checkOutput("async_rst_dout", 32'(dout), 32'h0);
        checkOutput("async_rst_rise", 32'(rise), 32'h0);
        checkOutput("async_rst_fall", 32'(fall), 32'h0);
        checkOutput("async_rst_tick", 32'(tick), 32'h0);
        clearMonitors();
        stepClk(2);
        @(posedge clk);
        #3;
        rst_a_p = 1'b0;
        stepClk(4);
        checkOutput("midrst_tick", 32'(tick), 32'h1);
        stepClk(8);
        checkOutput("midrst_wait_dout", 32'(dout), 32'h0);
        checkOutput("midrst_no_pulse", 32'(riseSeen | fallSeen), 32'h0);
        stepClk(1);
        checkOutput("midrst_dout", 32'(dout), 32'h3);
        checkOutput("midrst_rise", 32'(rise), 32'h3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Multi-channel, fully synchronous push-button/switch debouncer. It generalises the single-input debouncer in four ways:
- N_CH independent channels share one sample-tick divider.
- Each input passes through a 2-FF synchroniser.
- The output changes only after STABLE_CNT consecutive agreeing samples.
- Each channel emits one-cycle rise and fall pulses.

It sits between raw board I/O (buttons, switches) and control logic such as counters and FSMs.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- TICK_DIV, 5000, clk cycles per sample tick (>=1; 1 means a tick every cycle).
- STABLE_CNT, 4, consecutive differing samples required before an output changes (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_a_p  input  1  reset, asynchronous, active-high.
- en  input  1  sample enable; 0 freezes the tick divider and all channel state.
- din  input  N_CH  raw asynchronous inputs, bit i = channel i.
- dout  output  N_CH  debounced level per channel.
- rise  output  N_CH  one-clk pulse when dout[i] goes 0->1.
- fall  output  N_CH  one-clk pulse when dout[i] goes 1->0.
- tick  output  1  sample strobe, high one clk per TICK_DIV cycles while en=1.

Behaviour:
- **Single clock domain.** No derived clocks; the tick is a clock enable.
- **Reset (async, rst_a_p=1).** The following clear immediately and hold while reset is asserted: tick counter=0, tick=0, sync FFs=0, per-channel stable counters=0, dout=0, rise=0, fall=0.
- **Synchroniser.** `s1 <= din; s2 <= s1` every clk regardless of en. Channel logic uses s2 only.
- **Tick divider.**
  - Counter width is ceil(log2(TICK_DIV)), minimum 1.
  - With en=1 it counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered: high in the cycle after the counter equals TICK_DIV-1.
  - The first tick therefore occurs TICK_DIV cycles after reset release with en=1.
  - en=0: counter holds, tick=0.
  - TICK_DIV=1: tick is high every cycle while en=1.
- **Per-channel filter.** Evaluated only on clk edges where tick=1.
  - Stable counter cnt[i] has width ceil(log2(STABLE_CNT+1)).
  - If s2[i]==dout[i]: cnt[i] <= 0.
  - If s2[i]!=dout[i] and cnt[i]==STABLE_CNT-1: dout[i] <= s2[i], cnt[i] <= 0, and the matching rise[i]/fall[i] <= 1.
  - If s2[i]!=dout[i] and cnt[i]<STABLE_CNT-1: cnt[i] <= cnt[i]+1.
  - cnt never exceeds STABLE_CNT-1; no wrap-around is possible.
- **Pulses.** rise and fall are registered and are high for exactly one clk, coincident with the first cycle of the new dout value. On all other edges they are 0. rise[i] and fall[i] are never high together.
- **Glitch rejection.** Any tick where s2[i]==dout[i] restarts the count. A bounce shorter than STABLE_CNT consecutive ticks never reaches dout.
- **Latency.** From a din edge to dout: 2 clk (synchroniser) + wait to next tick + (STABLE_CNT-1)·TICK_DIV + 1 clk. Maximum is 2 + STABLE_CNT·TICK_DIV + 1 clk.
- **Channel independence.** Channels share only tick. Simultaneous transitions on several channels update in the same cycle.
- **Reset mid-count.** Partial counts are discarded, dout=0, and any pending pulse is cancelled. If din is held 1 through reset, a rise follows after the full latency once reset is released.
- **en deasserted mid-count.** cnt values and the divider phase are retained. Counting resumes on re-enable with no spurious tick.

Test Plan:
Bench settings: N_CH=4, TICK_DIV=4, STABLE_CNT=3, en=1.

1. **Reset values.** Assert rst_a_p mid-simulation, asynchronously between clk edges -> dout, rise, fall, tick are 0 before the next clk edge. tick then appears every 4th cycle after release.
2. **Clean press.** din[0] 0->1 and held -> dout[0]=1 after the 3rd agreeing tick. rise[0] is high for exactly 1 clk in that same cycle. fall=0 throughout. Other channels stay 0.
3. **Bounce rejection.** din[1] toggled high for 2 ticks, low for 1 tick, repeated 5 times, then held high -> no rise[1] during bouncing. Exactly one rise[1] occurs 3 ticks after the final stable high.
4. **Release and simultaneous channels.** din[3:2] 11->00 at the same clk after both debounced high -> dout[3:2]=00 in the same cycle. fall[3:2]=11 for 1 clk. rise stays 0.
5. **en freeze.** Drop en after 2 agreeing ticks on din[0] for 20 clk, then re-enable -> no tick while en=0. dout[0] changes on the first tick after re-enable.
6. **Reset mid-count.** Pulse rst_a_p after 2 agreeing ticks with din[0]=1 held -> dout[0]=0 and no pulse. rise[0] occurs 3 full ticks (plus sync latency) after release.
